// File: rtl/ysyx_24100027_pkg.sv
// Shared definitions for the ysyx_24100027 instruction fetch unit:
// FSM state encodings, fault cause codes, reset constants and small helpers.
package ysyx_24100027_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } ifu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_BUS_ERR  = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } fault_cause_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [15:0] TIMEOUT_DEFAULT  = 16'd1024;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // Instructions are word aligned; any low address bit set is a misaligned target.
    function automatic logic pc_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24100027_ifu_if.sv
// Instruction memory request/response bus: the IFU is the master, memory the slave.
interface ysyx_24100027_ifu_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/ysyx_24100027_ifu_wdog.sv
// Fetch watchdog: counts enabled cycles and flags expiry on the TIMEOUT-th one.
module ysyx_24100027_ifu_wdog #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] cnt_r;
    logic        expire_r;

    // Expiry is precomputed one count early so the flag is a register yet
    // still lands on exactly the TIMEOUT-th enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= 16'd0;
            expire_r <= 1'b0;
        end else if (clr) begin
            cnt_r    <= 16'd0;
            expire_r <= 1'b0;
        end else if (en) begin
            cnt_r    <= cnt_r + 16'd1;
            expire_r <= (cnt_r == (TIMEOUT - 16'd2));
        end else begin
            cnt_r    <= cnt_r;
            expire_r <= expire_r;
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the architectural PC, fetches over a valid/ready bus,
// holds each instruction for the core until commit, and traps on bus, timeout or alignment faults.
module ysyx_24100027_ifu
    import ysyx_24100027_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [15:0] TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24100027_ifu_if.master imem,
    output logic [31:0]         pc,
    output logic [31:0]         inst,
    output logic                inst_valid,
    input  logic                commit,
    input  logic [31:0]         npc,
    input  logic                halt_req,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_cause,
    output logic [31:0]         fault_pc,
    output logic [31:0]         instret
);

    ifu_state_e   state_r;
    ifu_state_e   next_state_s;
    fault_cause_e cause_r;
    fault_cause_e cause_s;
    logic [31:0]  pc_r;
    logic [31:0]  inst_r;
    logic [31:0]  fault_pc_r;
    logic [31:0]  fault_pc_s;
    logic [31:0]  instret_r;
    logic         halted_r;
    logic         fault_r;
    logic         capture_s;
    logic         load_pc_s;
    logic         retire_s;
    logic         set_halt_s;
    logic         set_fault_s;
    logic         in_wait_s;
    logic         wdog_expire_s;

    assign in_wait_s = (state_r == ST_WAIT);

    ysyx_24100027_ifu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (~in_wait_s),
        .en     (in_wait_s),
        .expire (wdog_expire_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus one-cycle load/retire/fault strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        load_pc_s    = 1'b0;
        retire_s     = 1'b0;
        set_halt_s   = 1'b0;
        set_fault_s  = 1'b0;
        cause_s      = CAUSE_NONE;
        fault_pc_s   = pc_r;
        case (state_r)
            ST_FETCH: begin
                // A response in the accept cycle is a zero-wait memory; anything
                // arriving without an accept is stale and dropped.
                if (imem.req_ready) begin
                    if (imem.rsp_valid) begin
                        if (imem.rsp_err) begin
                            next_state_s = ST_FAULT;
                            set_fault_s  = 1'b1;
                            cause_s      = CAUSE_BUS_ERR;
                        end else begin
                            next_state_s = ST_EXEC;
                            capture_s    = 1'b1;
                        end
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (imem.rsp_valid) begin
                    if (imem.rsp_err) begin
                        next_state_s = ST_FAULT;
                        set_fault_s  = 1'b1;
                        cause_s      = CAUSE_BUS_ERR;
                    end else begin
                        next_state_s = ST_EXEC;
                        capture_s    = 1'b1;
                    end
                end else if (wdog_expire_s) begin
                    next_state_s = ST_FAULT;
                    set_fault_s  = 1'b1;
                    cause_s      = CAUSE_TIMEOUT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_EXEC: begin
                if (commit) begin
                    retire_s = 1'b1;
                    if (halt_req) begin
                        next_state_s = ST_HALT;
                        set_halt_s   = 1'b1;
                    end else if (pc_misaligned(npc)) begin
                        next_state_s = ST_FAULT;
                        set_fault_s  = 1'b1;
                        cause_s      = CAUSE_MISALIGN;
                        fault_pc_s   = npc;
                    end else begin
                        next_state_s = ST_FETCH;
                        load_pc_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            ST_FAULT: begin
                next_state_s = ST_FAULT;
            end
            default: begin
                // An illegal encoding parks the unit rather than fetching from an unknown PC.
                next_state_s = ST_FAULT;
                set_fault_s  = 1'b1;
            end
        endcase
    end

    // Architectural PC, instruction latch, retire counter and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            inst_r     <= NOP_INST;
            instret_r  <= 32'd0;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
            cause_r    <= CAUSE_NONE;
            fault_pc_r <= 32'd0;
        end else begin
            if (capture_s) begin
                inst_r <= imem.rsp_data;
            end
            if (load_pc_s) begin
                pc_r <= npc;
            end
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end
            if (set_halt_s) begin
                halted_r <= 1'b1;
            end
            if (set_fault_s) begin
                fault_r    <= 1'b1;
                cause_r    <= cause_s;
                fault_pc_r <= fault_pc_s;
            end
        end
    end

    assign imem.req_valid = (state_r == ST_FETCH);
    assign imem.req_addr  = pc_r;
    assign inst_valid     = (state_r == ST_EXEC);
    assign pc             = pc_r;
    assign inst           = inst_r;
    assign instret        = instret_r;
    assign halted         = halted_r;
    assign fault          = fault_r;
    assign fault_cause    = cause_r;
    assign fault_pc       = fault_pc_r;

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Scoreboard bench for ysyx_24100027_ifu: a driver plays memory and core, a reference
// model queues expected fetches, executions and terminal events, and a monitor checks them.
module tb_ysyx_24100027_ifu;
    import ysyx_24100027_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int          TMO = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] instret;
    } exec_t;

    typedef struct packed {
        logic        is_halt;
        logic [1:0]  cause;
        logic [31:0] fpc;
        logic [31:0] pc;
        logic [31:0] instret;
    } term_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic [31:0] npc;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] instret;
    longint      cyc = 0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    exec_t       exp_exec_q[$];
    term_t       exp_term_q[$];
    logic [31:0] ref_pc;
    logic [31:0] ref_instret;

    ysyx_24100027_ifu_if imem ();

    ysyx_24100027_ifu #(
        .RESET_PC (RPC),
        .TIMEOUT  (16'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .commit      (commit),
        .npc         (npc),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .instret     (instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: a fixed scramble of the address, distinct from the nop.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic term_t mk_term(input logic h, input logic [1:0] c, input logic [31:0] f,
                                      input logic [31:0] p, input logic [31:0] n);
        term_t t;
        t.is_halt = h; t.cause = c; t.fpc = f; t.pc = p; t.instret = n;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Monitor: samples 2 time units after the falling edge, after the driver has settled.
    logic        req_open = 1'b0;
    logic [31:0] held_addr = 32'd0;
    logic        prev_exec = 1'b0, prev_fault = 1'b0, prev_halt = 1'b0, term_active = 1'b0;
    logic [31:0] term_pc = 32'd0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                req_open = 1'b0; prev_exec = 1'b0; prev_fault = 1'b0;
                prev_halt = 1'b0; term_active = 1'b0;
            end else begin
                if (imem.req_valid) begin
                    if (!req_open) begin
                        if (exp_addr_q.size() == 0) fail_now("unexpected_fetch", imem.req_addr);
                        else begin
                            held_addr = exp_addr_q.pop_front();
                            check("fetch_addr", imem.req_addr, held_addr);
                        end
                        req_open = 1'b1;
                    end else begin
                        check("addr_stable", imem.req_addr, held_addr);
                    end
                    if (imem.req_ready) req_open = 1'b0;
                end else if (req_open) begin
                    fail_now("req_withdrawn", held_addr);
                    req_open = 1'b0;
                end
                if (inst_valid && !prev_exec) begin
                    if (exp_exec_q.size() == 0) fail_now("unexpected_exec", pc);
                    else begin
                        exec_t e;
                        e = exp_exec_q.pop_front();
                        check("exec_pc", pc, e.pc);
                        check("exec_inst", inst, e.inst);
                        check("exec_instret", instret, e.instret);
                    end
                end
                if ((fault && !prev_fault) || (halted && !prev_halt)) begin
                    if (exp_term_q.size() == 0) fail_now("unexpected_terminal", {30'd0, halted, fault});
                    else begin
                        term_t t;
                        t = exp_term_q.pop_front();
                        check("term_kind", {30'd0, halted, fault}, {30'd0, t.is_halt, ~t.is_halt});
                        check("term_cause", 32'(fault_cause), 32'(t.cause));
                        check("term_fault_pc", fault_pc, t.fpc);
                        check("term_instret", instret, t.instret);
                        term_pc = t.pc;
                    end
                    term_active = 1'b1;
                end
                if (term_active) begin
                    check("term_quiet", {30'd0, imem.req_valid, inst_valid}, 32'd0);
                    check("term_pc_held", pc, term_pc);
                end
                prev_exec  = inst_valid;
                prev_fault = fault;
                prev_halt  = halted;
            end
        end
    end

    task automatic drive_rsp(input bit err);
        imem.rsp_valid = 1'b1;
        imem.rsp_err   = err;
        imem.rsp_data  = err ? $urandom : mem_word(ref_pc);
        if (err) exp_term_q.push_back(mk_term(1'b0, 2'd1, ref_pc, ref_pc, ref_instret));
        else     exp_exec_q.push_back('{pc: ref_pc, inst: mem_word(ref_pc), instret: ref_instret});
    endtask

    // Serve one fetch at ref_pc; commit pulses while not executing must be ignored.
    task automatic serve_fetch(input int rdy_dly, input int rsp_dly, input bit err, input bit no_rsp);
        int n = 0;
        while (!imem.req_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!imem.req_valid) begin
            fail_now("fetch_wait_expired", ref_pc);
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                commit   = 1'($urandom_range(0, 1));
                halt_req = 1'($urandom_range(0, 1));
                npc      = $urandom;
                @(negedge clk);
            end
            commit = 1'b0; halt_req = 1'b0;
            imem.req_ready = 1'b1;
            if (rsp_dly == 0 && !no_rsp) drive_rsp(err);
            @(negedge clk);
            imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_err = 1'b0; imem.rsp_data = $urandom;
            if (!no_rsp && rsp_dly > 0) begin
                repeat (rsp_dly - 1) @(negedge clk);
                check("wait_not_exec", 32'(inst_valid), 32'd0);
                drive_rsp(err);
                @(negedge clk);
                imem.rsp_valid = 1'b0; imem.rsp_err = 1'b0; imem.rsp_data = $urandom;
            end
            if (!no_rsp) check("post_rsp_state", {30'd0, inst_valid, fault}, err ? 32'd1 : 32'd2);
        end
    endtask

    task automatic commit_inst(input int dly, input logic [31:0] nxt, input bit halt, output longint t_exec);
        int n = 0;
        while (!inst_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        t_exec = cyc;
        if (!inst_valid) begin
            fail_now("exec_wait_expired", ref_pc);
        end else begin
            repeat (dly) @(negedge clk);
            commit = 1'b1; npc = nxt; halt_req = halt;
            ref_instret = ref_instret + 32'd1;
            if (halt) exp_term_q.push_back(mk_term(1'b1, 2'd0, 32'd0, ref_pc, ref_instret));
            else if (nxt[1:0] != 2'b00) exp_term_q.push_back(mk_term(1'b0, 2'd3, nxt, ref_pc, ref_instret));
            else begin
                ref_pc = nxt;
                exp_addr_q.push_back(nxt);
            end
            @(negedge clk);
            commit = 1'b0; halt_req = 1'b0; npc = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; commit = 1'b0; halt_req = 1'b0;
        imem.req_ready = 1'b0; imem.rsp_valid = 1'b0; imem.rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RPC);
        check("rst_inst", inst, NOP_INST);
        check("rst_flags", {29'd0, inst_valid, halted, fault}, 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("queues_drained", 32'(exp_addr_q.size() + exp_exec_q.size() + exp_term_q.size()), 32'd0);
        ref_pc = RPC; ref_instret = 32'd0;
        exp_addr_q.push_back(RPC);
        rst = 1'b0;
    endtask

    initial begin
        longint t0, t1, t2;
        int     k;
        logic [31:0] nxt;
        npc = 32'd0; imem.rsp_data = 32'd0;
        do_reset();

        // Zero-wait loop, sequential npc.
        serve_fetch(0, 0, 0, 0); commit_inst(0, ref_pc + 32'd4, 0, t0);
        serve_fetch(0, 0, 0, 0); commit_inst(0, ref_pc + 32'd4, 0, t1);
        serve_fetch(0, 0, 0, 0); commit_inst(0, ref_pc + 32'd4, 0, t2);
        check("two_cycles_per_inst", 32'(t2 - t0), 32'd4);
        check("instret_after_3", instret, 32'd3);

        // Slow accept then delayed response, then bus error on the next fetch.
        serve_fetch(5, 3, 0, 0); commit_inst(1, 32'h8000_0010, 0, t0);
        serve_fetch(0, 2, 1, 0);
        repeat (5) @(negedge clk);

        // Watchdog: no response ever arrives.
        do_reset();
        serve_fetch(0, 0, 0, 1);
        exp_term_q.push_back(mk_term(1'b0, 2'd2, ref_pc, ref_pc, ref_instret));
        k = 0;
        while (!fault && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TMO));
        repeat (3) @(negedge clk);

        // Misaligned npc.
        do_reset();
        serve_fetch(0, 0, 0, 0); commit_inst(0, 32'h8000_0006, 0, t0);
        repeat (4) @(negedge clk);

        // Halt with a junk npc, pc must stay put.
        do_reset();
        serve_fetch(0, 1, 0, 0); commit_inst(2, 32'h1234_5678, 1, t0);
        repeat (5) @(negedge clk);

        // Reset while waiting; the late response must be ignored.
        do_reset();
        serve_fetch(0, 0, 0, 1);
        repeat (2) @(negedge clk);
        do_reset();
        imem.rsp_valid = 1'b1; imem.rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem.rsp_valid = 1'b0;
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            serve_fetch($urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            if ($urandom_range(0, 3) == 0) nxt = {8'h80, 22'($urandom), 2'b00};
            else                           nxt = ref_pc + 32'd4;
            commit_inst($urandom_range(0, 2), nxt, 0, t0);
        end
        serve_fetch(1, 1, 0, 0); commit_inst(0, 32'd0, 1, t0);
        repeat (4) @(negedge clk);
        check("final_queues_drained", 32'(exp_addr_q.size() + exp_exec_q.size() + exp_term_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete");
        total++;
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
